// File: rtl/ibex_rf_writeback_ctrl_if.sv
// Register-file writeback bundle: EX results, load issue/response, write port and decode read ports.
interface ibex_rf_writeback_ctrl_if #(
    parameter int unsigned DataWidth = 32
);
    logic                 ex_valid_i;
    logic [4:0]           ex_waddr_i;
    logic [DataWidth-1:0] ex_wdata_i;
    logic                 ex_ready_o;
    logic                 ld_issue_i;
    logic [4:0]           ld_rd_i;
    logic                 ld_ready_o;
    logic                 lsu_rvalid_i;
    logic [DataWidth-1:0] lsu_rdata_i;
    logic                 lsu_err_i;
    logic                 we_a_o;
    logic [4:0]           waddr_a_o;
    logic [DataWidth-1:0] wdata_a_o;
    logic [4:0]           raddr_a_i;
    logic [4:0]           raddr_b_i;
    logic [DataWidth-1:0] rf_rdata_a_i;
    logic [DataWidth-1:0] rf_rdata_b_i;
    logic [DataWidth-1:0] rdata_a_o;
    logic [DataWidth-1:0] rdata_b_o;
    logic                 hazard_a_o;
    logic                 hazard_b_o;
    logic                 ld_busy_o;

    modport master (
        output ex_valid_i, ex_waddr_i, ex_wdata_i, ld_issue_i, ld_rd_i,
               lsu_rvalid_i, lsu_rdata_i, lsu_err_i,
               raddr_a_i, raddr_b_i, rf_rdata_a_i, rf_rdata_b_i,
        input  ex_ready_o, ld_ready_o, we_a_o, waddr_a_o, wdata_a_o,
               rdata_a_o, rdata_b_o, hazard_a_o, hazard_b_o, ld_busy_o
    );

    modport slave (
        input  ex_valid_i, ex_waddr_i, ex_wdata_i, ld_issue_i, ld_rd_i,
               lsu_rvalid_i, lsu_rdata_i, lsu_err_i,
               raddr_a_i, raddr_b_i, rf_rdata_a_i, rf_rdata_b_i,
        output ex_ready_o, ld_ready_o, we_a_o, waddr_a_o, wdata_a_o,
               rdata_a_o, rdata_b_o, hazard_a_o, hazard_b_o, ld_busy_o
    );
endinterface

// File: rtl/ibex_rf_writeback_ctrl.sv
// Register-file write-port owner: arbitrates EX vs load responses, tracks the outstanding
// load destination and forwards the write-stage value onto both decode read ports.
module ibex_rf_writeback_ctrl #(
    parameter int unsigned          DataWidth   = 32,
    parameter bit                   RV32E       = 1'b0,
    parameter logic [DataWidth-1:0] WordZeroVal = '0
) (
    input  logic                      clk_i,
    input  logic                      rst_ni,
    ibex_rf_writeback_ctrl_if.slave   bus
);
    localparam int unsigned NumRegs = 32;
    localparam int unsigned AddrW   = 5;

    typedef enum logic {
        IDLE    = 1'b0,
        LD_WAIT = 1'b1
    } state_e;

    state_e               r_state;
    state_e               w_state_nxt;
    logic [AddrW-1:0]     r_ld_rd;
    logic [AddrW-1:0]     w_ld_rd_nxt;
    logic [NumRegs-1:0]   r_pending;
    logic [NumRegs-1:0]   w_set;
    logic [NumRegs-1:0]   w_clr;
    logic                 w_ld_ready;
    logic                 w_rsp;
    logic                 w_issue;
    logic                 w_ex_ready;
    logic                 w_ex_win;
    logic                 r_we;
    logic [AddrW-1:0]     r_waddr;
    logic [DataWidth-1:0] r_wdata;

    // Register index that may be written/tracked: not x0 and inside the RV32E range.
    function automatic logic f_addr_ok(input logic [AddrW-1:0] a);
        return (a != AddrW'(0)) && !(RV32E && a[AddrW-1]);
    endfunction

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_state <= IDLE;
            r_ld_rd <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_ld_rd <= w_ld_rd_nxt;
        end
    end

    // A new load is accepted while idle, or back-to-back with the response that frees the slot.
    always_comb begin
        w_state_nxt = r_state;
        w_ld_rd_nxt = r_ld_rd;
        w_ld_ready  = 1'b0;
        w_rsp       = 1'b0;
        case (r_state)
            IDLE: begin
                w_ld_ready = 1'b1;
                if (bus.ld_issue_i) begin
                    w_state_nxt = LD_WAIT;
                    w_ld_rd_nxt = bus.ld_rd_i;
                end
            end
            LD_WAIT: begin
                w_ld_ready = bus.lsu_rvalid_i;
                w_rsp      = bus.lsu_rvalid_i;
                if (bus.lsu_rvalid_i) begin
                    w_state_nxt = IDLE;
                    if (bus.ld_issue_i) begin
                        w_state_nxt = LD_WAIT;
                        w_ld_rd_nxt = bus.ld_rd_i;
                    end
                end
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    assign w_issue = bus.ld_issue_i & w_ld_ready;
    assign w_set   = (w_issue && f_addr_ok(bus.ld_rd_i)) ? (NumRegs'(1) << bus.ld_rd_i) : '0;
    assign w_clr   = w_rsp ? (NumRegs'(1) << r_ld_rd) : '0;

    // Set is applied after clear so a same-rd issue/response pair leaves the bit pending.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) r_pending <= '0;
        else         r_pending <= (r_pending & ~w_clr) | w_set;
    end

    assign w_ex_ready = ~bus.lsu_rvalid_i &
                        ~((r_state == LD_WAIT) && (bus.ex_waddr_i == r_ld_rd) &&
                          (bus.ex_waddr_i != AddrW'(0)));
    assign w_ex_win   = bus.ex_valid_i & w_ex_ready & f_addr_ok(bus.ex_waddr_i);

    // Write stage: load response has priority; dropped writes keep address/data stable.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_we    <= 1'b0;
            r_waddr <= '0;
            r_wdata <= WordZeroVal;
        end else if (w_rsp) begin
            r_we <= ~bus.lsu_err_i & f_addr_ok(r_ld_rd);
            if (~bus.lsu_err_i && f_addr_ok(r_ld_rd)) begin
                r_waddr <= r_ld_rd;
                r_wdata <= bus.lsu_rdata_i;
            end
        end else if (w_ex_win) begin
            r_we    <= 1'b1;
            r_waddr <= bus.ex_waddr_i;
            r_wdata <= bus.ex_wdata_i;
        end else begin
            r_we <= 1'b0;
        end
    end

    assign bus.ex_ready_o = w_ex_ready;
    assign bus.ld_ready_o = w_ld_ready;
    assign bus.ld_busy_o  = (r_state == LD_WAIT);
    assign bus.we_a_o     = r_we;
    assign bus.waddr_a_o  = r_waddr;
    assign bus.wdata_a_o  = r_wdata;

    assign bus.hazard_a_o = r_pending[bus.raddr_a_i] & (bus.raddr_a_i != AddrW'(0));
    assign bus.hazard_b_o = r_pending[bus.raddr_b_i] & (bus.raddr_b_i != AddrW'(0));

    assign bus.rdata_a_o = (r_we && (r_waddr == bus.raddr_a_i) && (bus.raddr_a_i != AddrW'(0)))
                           ? r_wdata : bus.rf_rdata_a_i;
    assign bus.rdata_b_o = (r_we && (r_waddr == bus.raddr_b_i) && (bus.raddr_b_i != AddrW'(0)))
                           ? r_wdata : bus.rf_rdata_b_i;
endmodule

// File: tb/tb_ibex_rf_writeback_ctrl.sv
// Directed and randomized checks of the writeback controller against a queue-based reference model.
module tb_ibex_rf_writeback_ctrl;
    logic clk;
    logic rst_ni;

    ibex_rf_writeback_ctrl_if #(.DataWidth(32)) bus ();

    ibex_rf_writeback_ctrl #(.DataWidth(32), .RV32E(1'b0), .WordZeroVal(32'h0)) dut (
        .clk_i  (clk),
        .rst_ni (rst_ni),
        .bus    (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_assert = 0;
    int n_fail   = 0;

    // Reference model: at most one outstanding load, kept as a queue of destinations.
    logic [4:0]  q[$];
    logic        m_we;
    logic [4:0]  m_waddr;
    logic [31:0] m_wdata;
    logic        n_we;
    logic [4:0]  n_waddr;
    logic [31:0] n_wdata;
    logic        do_pop;
    logic        do_push;
    logic [4:0]  push_rd;
    logic [31:0] dut_last[32];

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic idle();
        bus.ex_valid_i   = 1'b0;
        bus.ex_waddr_i   = 5'd0;
        bus.ex_wdata_i   = 32'h0;
        bus.ld_issue_i   = 1'b0;
        bus.ld_rd_i      = 5'd0;
        bus.lsu_rvalid_i = 1'b0;
        bus.lsu_rdata_i  = 32'h0;
        bus.lsu_err_i    = 1'b0;
        bus.raddr_a_i    = 5'd0;
        bus.raddr_b_i    = 5'd0;
        bus.rf_rdata_a_i = 32'h0;
        bus.rf_rdata_b_i = 32'h0;
    endtask

    // Compare every output against the model at the falling edge and plan the next model state.
    task automatic sample();
        logic busy, ex_rdy, ld_rdy, haz_a, haz_b;
        logic [4:0]  cur;
        logic [31:0] exp_a, exp_b;
        @(negedge clk);
        busy   = (q.size() != 0);
        cur    = busy ? q[0] : 5'd0;
        ex_rdy = !bus.lsu_rvalid_i && !(busy && bus.ex_waddr_i == cur && bus.ex_waddr_i != 5'd0);
        ld_rdy = !busy || bus.lsu_rvalid_i;
        haz_a  = busy && bus.raddr_a_i == cur && bus.raddr_a_i != 5'd0;
        haz_b  = busy && bus.raddr_b_i == cur && bus.raddr_b_i != 5'd0;
        exp_a  = (m_we && m_waddr == bus.raddr_a_i && bus.raddr_a_i != 5'd0) ? m_wdata : bus.rf_rdata_a_i;
        exp_b  = (m_we && m_waddr == bus.raddr_b_i && bus.raddr_b_i != 5'd0) ? m_wdata : bus.rf_rdata_b_i;
        chk("ld_busy",  64'(bus.ld_busy_o),  64'(busy));
        chk("ex_ready", 64'(bus.ex_ready_o), 64'(ex_rdy));
        chk("ld_ready", 64'(bus.ld_ready_o), 64'(ld_rdy));
        chk("hazard_a", 64'(bus.hazard_a_o), 64'(haz_a));
        chk("hazard_b", 64'(bus.hazard_b_o), 64'(haz_b));
        chk("we_a",     64'(bus.we_a_o),     64'(m_we));
        chk("waddr_a",  64'(bus.waddr_a_o),  64'(m_waddr));
        chk("wdata_a",  64'(bus.wdata_a_o),  64'(m_wdata));
        chk("rdata_a",  64'(bus.rdata_a_o),  64'(exp_a));
        chk("rdata_b",  64'(bus.rdata_b_o),  64'(exp_b));
        if (bus.we_a_o) dut_last[bus.waddr_a_o] = bus.wdata_a_o;

        n_we = 1'b0; n_waddr = m_waddr; n_wdata = m_wdata;
        do_pop  = bus.lsu_rvalid_i && busy;
        do_push = bus.ld_issue_i && ld_rdy;
        push_rd = bus.ld_rd_i;
        if (do_pop) begin
            if (!bus.lsu_err_i && cur != 5'd0) begin
                n_we = 1'b1; n_waddr = cur; n_wdata = bus.lsu_rdata_i;
            end
        end else if (bus.ex_valid_i && ex_rdy && bus.ex_waddr_i != 5'd0) begin
            n_we = 1'b1; n_waddr = bus.ex_waddr_i; n_wdata = bus.ex_wdata_i;
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        m_we = n_we; m_waddr = n_waddr; m_wdata = n_wdata;
        if (do_pop) void'(q.pop_front());
        if (do_push) q.push_back(push_rd);
    endtask

    task automatic step();
        sample();
        tick();
    endtask

    task automatic do_reset();
        rst_ni = 1'b0;
        #2;
        chk("rst_ld_busy",  64'(bus.ld_busy_o),  64'(0));
        chk("rst_we_a",     64'(bus.we_a_o),     64'(0));
        chk("rst_hazard_a", 64'(bus.hazard_a_o), 64'(0));
        chk("rst_hazard_b", 64'(bus.hazard_b_o), 64'(0));
        chk("rst_waddr_a",  64'(bus.waddr_a_o),  64'(0));
        chk("rst_wdata_a",  64'(bus.wdata_a_o),  64'(0));
        q.delete();
        m_we = 1'b0; m_waddr = 5'd0; m_wdata = 32'h0;
        @(posedge clk);
        #1;
        rst_ni = 1'b1;
    endtask

    initial begin
        rst_ni = 1'b1;
        idle();
        for (int i = 0; i < 32; i++) dut_last[i] = 32'h0;
        #1;
        do_reset();
        step();

        // EX write x5, forwarded the next cycle over stale RF data
        bus.ex_valid_i = 1'b1; bus.ex_waddr_i = 5'd5; bus.ex_wdata_i = 32'h1234_5678;
        step();
        idle(); bus.raddr_a_i = 5'd5; bus.rf_rdata_a_i = 32'hAAAA_AAAA;
        sample();
        chk("t1_we", 64'(bus.we_a_o), 64'(1));
        chk("t1_waddr", 64'(bus.waddr_a_o), 64'(5));
        chk("t1_rdata_a", 64'(bus.rdata_a_o), 64'h1234_5678);
        tick();

        // Load x7, response three cycles after issue
        idle(); bus.ld_issue_i = 1'b1; bus.ld_rd_i = 5'd7; bus.raddr_a_i = 5'd7;
        sample(); chk("t2_haz_issue", 64'(bus.hazard_a_o), 64'(0)); tick();
        bus.ld_issue_i = 1'b0;
        for (int i = 0; i < 2; i++) begin
            sample(); chk("t2_haz_wait", 64'(bus.hazard_a_o), 64'(1)); tick();
        end
        bus.lsu_rvalid_i = 1'b1; bus.lsu_rdata_i = 32'hDEAD_BEEF;
        sample(); chk("t2_haz_rsp", 64'(bus.hazard_a_o), 64'(1)); tick();
        bus.lsu_rvalid_i = 1'b0; bus.rf_rdata_a_i = 32'h5555_5555;
        sample();
        chk("t2_we", 64'(bus.we_a_o), 64'(1));
        chk("t2_waddr", 64'(bus.waddr_a_o), 64'(7));
        chk("t2_wdata", 64'(bus.wdata_a_o), 64'hDEAD_BEEF);
        chk("t2_busy", 64'(bus.ld_busy_o), 64'(0));
        chk("t2_fwd", 64'(bus.rdata_a_o), 64'hDEAD_BEEF);
        tick();

        // Load response and EX x3 collide: load wins, EX follows
        idle(); bus.ld_issue_i = 1'b1; bus.ld_rd_i = 5'd2;
        step();
        idle(); step();
        bus.lsu_rvalid_i = 1'b1; bus.lsu_rdata_i = 32'h0000_0222;
        bus.ex_valid_i = 1'b1; bus.ex_waddr_i = 5'd3; bus.ex_wdata_i = 32'h0000_0333;
        sample(); chk("t3_ex_stall", 64'(bus.ex_ready_o), 64'(0)); tick();
        bus.lsu_rvalid_i = 1'b0;
        sample();
        chk("t3_ex_acc", 64'(bus.ex_ready_o), 64'(1));
        chk("t3_ld_waddr", 64'(bus.waddr_a_o), 64'(2));
        tick();
        idle();
        sample();
        chk("t3_ex_waddr", 64'(bus.waddr_a_o), 64'(3));
        chk("t3_ex_wdata", 64'(bus.wdata_a_o), 64'h333);
        tick();

        // WAW: EX to x9 stalls behind the outstanding load to x9
        idle(); bus.ld_issue_i = 1'b1; bus.ld_rd_i = 5'd9;
        step();
        idle(); bus.ex_valid_i = 1'b1; bus.ex_waddr_i = 5'd9; bus.ex_wdata_i = 32'h9999_9999;
        for (int i = 0; i < 2; i++) begin
            sample(); chk("t4_waw_stall", 64'(bus.ex_ready_o), 64'(0)); tick();
        end
        bus.lsu_rvalid_i = 1'b1; bus.lsu_rdata_i = 32'h1111_1111;
        sample(); chk("t4_rsp_stall", 64'(bus.ex_ready_o), 64'(0)); tick();
        bus.lsu_rvalid_i = 1'b0;
        sample();
        chk("t4_ex_acc", 64'(bus.ex_ready_o), 64'(1));
        chk("t4_ld_wdata", 64'(bus.wdata_a_o), 64'h1111_1111);
        tick();
        idle(); step();
        chk("t4_final_x9", 64'(dut_last[9]), 64'h9999_9999);

        // Erroring load to x4: no write, pending cleared, FSM idle
        idle(); bus.ld_issue_i = 1'b1; bus.ld_rd_i = 5'd4; bus.raddr_a_i = 5'd4;
        step();
        bus.ld_issue_i = 1'b0; bus.lsu_rvalid_i = 1'b1; bus.lsu_err_i = 1'b1;
        bus.lsu_rdata_i = 32'hBAD0_BAD0;
        sample(); chk("t5_haz_err", 64'(bus.hazard_a_o), 64'(1)); tick();
        bus.lsu_rvalid_i = 1'b0; bus.lsu_err_i = 1'b0;
        sample();
        chk("t5_err_we", 64'(bus.we_a_o), 64'(0));
        chk("t5_err_haz", 64'(bus.hazard_a_o), 64'(0));
        chk("t5_err_busy", 64'(bus.ld_busy_o), 64'(0));
        tick();

        // x0 writes and loads are discarded and never hazard
        idle(); bus.ex_valid_i = 1'b1; bus.ex_waddr_i = 5'd0; bus.ex_wdata_i = 32'hFFFF_FFFF;
        step();
        idle(); bus.ld_issue_i = 1'b1; bus.ld_rd_i = 5'd0;
        sample(); chk("t5_x0_we", 64'(bus.we_a_o), 64'(0)); tick();
        bus.ld_issue_i = 1'b0;
        sample(); chk("t5_x0_haz", 64'(bus.hazard_a_o), 64'(0)); tick();
        bus.lsu_rvalid_i = 1'b1; bus.lsu_rdata_i = 32'h0BAD_0000;
        step();
        idle();
        sample(); chk("t5_x0_ld_we", 64'(bus.we_a_o), 64'(0)); tick();

        // Reset during LD_WAIT drops the in-flight response
        idle(); bus.ld_issue_i = 1'b1; bus.ld_rd_i = 5'd6; bus.raddr_b_i = 5'd6;
        step();
        bus.ld_issue_i = 1'b0;
        sample(); chk("t6_haz_b", 64'(bus.hazard_b_o), 64'(1)); tick();
        do_reset();
        bus.lsu_rvalid_i = 1'b1; bus.lsu_rdata_i = 32'h6666_6666;
        step();
        bus.lsu_rvalid_i = 1'b0;
        sample(); chk("t6_no_write", 64'(bus.we_a_o), 64'(0)); tick();

        // Randomized traffic against the reference model
        for (int i = 0; i < 600; i++) begin
            bus.ex_valid_i   = ($urandom_range(0, 1) == 1);
            bus.ex_waddr_i   = 5'($urandom_range(0, 9));
            bus.ex_wdata_i   = $urandom;
            bus.ld_issue_i   = ($urandom_range(0, 3) == 0);
            bus.ld_rd_i      = 5'($urandom_range(0, 9));
            bus.lsu_rvalid_i = (q.size() != 0) ? ($urandom_range(0, 2) == 0)
                                               : ($urandom_range(0, 15) == 0);
            bus.lsu_err_i    = ($urandom_range(0, 7) == 0);
            bus.lsu_rdata_i  = $urandom;
            bus.raddr_a_i    = 5'($urandom_range(0, 9));
            bus.raddr_b_i    = 5'($urandom_range(0, 31));
            bus.rf_rdata_a_i = $urandom;
            bus.rf_rdata_b_i = $urandom;
            step();
        end
        idle();
        step();

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end
endmodule
